// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - 6502 / MARIA line-DMA bus ownership sequencer
module dma_bus_arbiter #(
    parameter int GUARD   = 2,
    parameter int TURN    = 1,
    parameter int MAX_DMA = 512,
    parameter int CW      = 16
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          dma_req,
    input  logic          dma_done,
    input  logic          cpu_cycle_end,
    input  logic          cpu_rd,
    output logic          halt_b,
    output logic          drive_AB,
    output logic          fast_clk_sel,
    output logic          dma_gnt,
    output logic          busy,
    output logic          overrun,
    output logic [CW-1:0] dma_cycles
);

    localparam int GT_MAX = (GUARD > TURN) ? GUARD : TURN;
    localparam int T_MAX  = (GT_MAX > MAX_DMA) ? GT_MAX : MAX_DMA;
    localparam int TW     = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_SETTLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          timeout_set;

    // One shared timer: guard countdown, grant-length count, turnaround countdown.
    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (dma_req) state_nxt = S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                if (!dma_req) begin
                    state_nxt = S_IDLE;
                end else if (cpu_cycle_end && cpu_rd) begin
                    if (GUARD == 0) begin
                        state_nxt = S_GRANT;
                        tmr_nxt   = '0;
                    end else begin
                        state_nxt = S_SETTLE;
                        tmr_nxt   = TW'(GUARD - 1);
                    end
                end
            end
            S_SETTLE: begin
                if (tmr == '0) begin
                    state_nxt = S_GRANT;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_GRANT: begin
                if (dma_done) begin
                    state_nxt = S_RELEASE;
                    tmr_nxt   = TW'(TURN);
                end else if (tmr == TW'(MAX_DMA - 1)) begin
                    state_nxt   = S_RELEASE;
                    tmr_nxt     = TW'(TURN);
                    timeout_set = 1'b1;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_RELEASE: begin
                if (tmr == '0) state_nxt = S_IDLE;
                else           tmr_nxt   = tmr - 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state flop.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            tmr          <= '0;
            halt_b       <= 1'b1;
            drive_AB     <= 1'b0;
            dma_gnt      <= 1'b0;
            fast_clk_sel <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            dma_cycles   <= '0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            halt_b       <= (state_nxt == S_IDLE);
            drive_AB     <= (state_nxt == S_GRANT);
            dma_gnt      <= (state_nxt == S_GRANT);
            fast_clk_sel <= (state_nxt == S_GRANT);
            busy         <= (state_nxt != S_IDLE);
            if (timeout_set)
                overrun <= 1'b1;
            if (state == S_GRANT)
                dma_cycles <= dma_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        dma_req, dma_done, cpu_cycle_end, cpu_rd;
    logic        halt_b, drive_AB, fast_clk_sel, dma_gnt, busy, overrun;
    logic [15:0] dma_cycles;
    logic        halt_b8, drive_AB8, fast_clk_sel8, dma_gnt8, busy8, overrun8;
    logic [15:0] dma_cycles8;

    int checks = 0;
    int errors = 0;

    dma_bus_arbiter #(.GUARD(2), .TURN(1), .MAX_DMA(512), .CW(16)) u_dut (
        .sysclk(sysclk), .reset(reset), .dma_req(dma_req), .dma_done(dma_done),
        .cpu_cycle_end(cpu_cycle_end), .cpu_rd(cpu_rd), .halt_b(halt_b),
        .drive_AB(drive_AB), .fast_clk_sel(fast_clk_sel), .dma_gnt(dma_gnt),
        .busy(busy), .overrun(overrun), .dma_cycles(dma_cycles)
    );

    dma_bus_arbiter #(.GUARD(2), .TURN(1), .MAX_DMA(8), .CW(16)) u_dut8 (
        .sysclk(sysclk), .reset(reset), .dma_req(dma_req), .dma_done(dma_done),
        .cpu_cycle_end(cpu_cycle_end), .cpu_rd(cpu_rd), .halt_b(halt_b8),
        .drive_AB(drive_AB8), .fast_clk_sel(fast_clk_sel8), .dma_gnt(dma_gnt8),
        .busy(busy8), .overrun(overrun8), .dma_cycles(dma_cycles8)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic req;
        logic done;
        logic cce;
        logic rd;
        logic e_halt_b;
        logic e_drive;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic req, input logic done, input logic cce,
                                input logic rd, input logic eh, input logic ed);
        vec_t v;
        v.req = req; v.done = done; v.cce = cce; v.rd = rd;
        v.e_halt_b = eh; v.e_drive = ed;
        tbl.push_back(v);
    endfunction

    task automatic drive_in(input logic req, input logic done, input logic cce, input logic rd);
        dma_req = req; dma_done = done; cpu_cycle_end = cce; cpu_rd = rd;
    endtask

    task automatic do_reset();
        drive_in(0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 reset = 1'b0;
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            step();
            chk($sformatf("%s[%0d] halt_b", name, i), 32'(halt_b), 32'(tbl[i].e_halt_b));
            chk($sformatf("%s[%0d] drive_AB", name, i), 32'(drive_AB), 32'(tbl[i].e_drive));
            chk($sformatf("%s[%0d] dma_gnt", name, i), 32'(dma_gnt), 32'(tbl[i].e_drive));
            chk($sformatf("%s[%0d] fast_clk_sel", name, i), 32'(fast_clk_sel), 32'(tbl[i].e_drive));
            chk($sformatf("%s[%0d] busy", name, i), 32'(busy), 32'(!tbl[i].e_halt_b));
            drive_in(tbl[i].req, tbl[i].done, tbl[i].cce, tbl[i].rd);
        end
        drive_in(0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        chk("rst halt_b", 32'(halt_b), 32'd1);
        chk("rst drive_AB", 32'(drive_AB), 32'd0);
        chk("rst dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst fast_clk_sel", 32'(fast_clk_sel), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst dma_cycles", 32'(dma_cycles), 32'd0);

        // Basic burst: req t0, read end t5, done t20.
        tbl.delete();
        for (int t = 0; t <= 24; t++)
            add(t <= 20, t == 20, t == 5, t == 5, !(t >= 1 && t <= 22), t >= 8 && t <= 20);
        do_reset();
        run_table("basic");
        chk("basic dma_cycles", 32'(dma_cycles), 32'd13);
        chk("basic overrun", 32'(overrun), 32'd0);

        // Write-cycle deferral; stray dma_done at t6 (HALT_WAIT) is ignored.
        tbl.delete();
        for (int t = 0; t <= 20; t++)
            add(t <= 15, t == 15 || t == 6, t == 3 || t == 9, t == 9,
                !(t >= 1 && t <= 17), t >= 12 && t <= 15);
        do_reset();
        run_table("defer");
        chk("defer dma_cycles", 32'(dma_cycles), 32'd4);

        // Withdrawn request.
        tbl.delete();
        for (int t = 0; t <= 9; t++)
            add(t <= 4, 1'b0, 1'b0, 1'b0, !(t >= 1 && t <= 5), 1'b0);
        do_reset();
        run_table("withdraw");
        chk("withdraw dma_cycles", 32'(dma_cycles), 32'd0);

        // MAX_DMA=8 collision: done on the 8th GRANT cycle is a normal release.
        do_reset();
        for (int t = 0; t <= 14; t++) begin
            step();
            chk($sformatf("coll[%0d] drive_AB", t), 32'(drive_AB8), 32'(t >= 4 && t <= 11));
            chk($sformatf("coll[%0d] halt_b", t), 32'(halt_b8), 32'(!(t >= 1 && t <= 13)));
            chk($sformatf("coll[%0d] overrun", t), 32'(overrun8), 32'd0);
            drive_in(t <= 11, t == 11, t == 1, t == 1);
        end
        drive_in(0, 0, 0, 0);
        chk("coll dma_cycles", 32'(dma_cycles8), 32'd8);

        // MAX_DMA=8 timeout: GRANT t4..t11, overrun from t12.
        do_reset();
        for (int t = 0; t <= 15; t++) begin
            step();
            chk($sformatf("tmo[%0d] drive_AB", t), 32'(drive_AB8), 32'(t >= 4 && t <= 11));
            chk($sformatf("tmo[%0d] halt_b", t), 32'(halt_b8), 32'(!(t >= 1 && t <= 13)));
            chk($sformatf("tmo[%0d] overrun", t), 32'(overrun8), 32'(t >= 12));
            drive_in(t <= 11, 1'b0, t == 1, t == 1);
        end
        drive_in(0, 0, 0, 0);
        chk("tmo dma_cycles", 32'(dma_cycles8), 32'd8);

        // Later normal burst: overrun stays sticky.
        for (int t = 0; t <= 12; t++) begin
            step();
            chk($sformatf("post[%0d] drive_AB", t), 32'(drive_AB8), 32'(t >= 4 && t <= 6));
            chk($sformatf("post[%0d] overrun", t), 32'(overrun8), 32'd1);
            drive_in(t <= 6, t == 6, t == 1, t == 1);
        end
        drive_in(0, 0, 0, 0);
        chk("post dma_cycles", 32'(dma_cycles8), 32'd11);

        // Asynchronous reset mid-GRANT, request still held.
        do_reset();
        for (int t = 0; t <= 6; t++) begin
            step();
            drive_in(1'b1, 1'b0, t == 1, t == 1);
        end
        chk("arst pre drive_AB", 32'(drive_AB), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("arst drive_AB", 32'(drive_AB), 32'd0);
        chk("arst halt_b", 32'(halt_b), 32'd1);
        chk("arst dma_gnt", 32'(dma_gnt), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst dma_cycles", 32'(dma_cycles), 32'd0);
        step();
        reset = 1'b0;
        chk("arst held halt_b", 32'(halt_b), 32'd1);
        step();
        chk("arst restart halt_b", 32'(halt_b), 32'd0);
        chk("arst restart drive_AB", 32'(drive_AB), 32'd0);
        chk("arst restart busy", 32'(busy), 32'd1);
        drive_in(1'b1, 1'b0, 1'b1, 1'b1);
        step();
        drive_in(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("arst settle drive_AB", 32'(drive_AB), 32'd0);
        step();
        step();
        chk("arst regrant drive_AB", 32'(drive_AB), 32'd1);
        drive_in(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Sequences ownership of the shared address/data bus between the 6502 core and MARIA line DMA.
- On a MARIA request it halts the CPU at a safe bus-cycle boundary (a read cycle) and grants MARIA the bus for the burst.
- It then hands the bus back through a turnaround state.
- It drives the halt_b / drive_AB pair and the fast-memory-clock select consumed by the memory clock mux and chip-select buffering.

Parameters:
- GUARD, 2: sysclk cycles between CPU halt taking effect and drive_AB assertion.
- TURN, 1: sysclk cycles between drive_AB deassertion and halt_b release.
- MAX_DMA, 512: maximum sysclk cycles in GRANT before a forced release.
- CW, 16: width of the dma_cycles statistics counter.

Ports:
- sysclk  in  1  system clock (7.16 MHz domain); all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dma_req  in  1  MARIA requests the bus; level, held until dma_done.
- dma_done  in  1  one-cycle pulse: MARIA finished its burst.
- cpu_cycle_end  in  1  one-cycle pulse on the last sysclk of each CPU bus cycle.
- cpu_rd  in  1  the CPU cycle ending at cpu_cycle_end is a read (RW=1).
- halt_b  out  1  active-low CPU halt.
- drive_AB  out  1  MARIA drives the address bus.
- fast_clk_sel  out  1  memory clock select: 1 = sysclk, 0 = pclk_0; equals drive_AB & ~halt_b.
- dma_gnt  out  1  bus granted to MARIA; same value as drive_AB.
- busy  out  1  state other than IDLE.
- overrun  out  1  sticky: a MAX_DMA forced release occurred; cleared only by reset.
- dma_cycles  out  CW  running count of sysclk cycles spent in GRANT; wraps modulo 2^CW.

Behaviour:
Reset (asynchronous, immediate on reset rising regardless of clock):
- state=IDLE, halt_b=1, drive_AB=0, dma_gnt=0, fast_clk_sel=0, busy=0, overrun=0, dma_cycles=0, counters=0.
- Reset mid-burst releases the bus immediately; there is no turnaround.

States:
- IDLE: halt_b=1, drive_AB=0. dma_req=1 -> HALT_WAIT on the next edge.
- HALT_WAIT: halt_b=0, drive_AB=0.
  - Waits for cpu_cycle_end=1 with cpu_rd=1, then -> SETTLE and loads the guard counter with GUARD-1.
  - cpu_cycle_end with cpu_rd=0 is ignored: the CPU may not be stopped in a write cycle.
  - dma_req dropping to 0 here -> IDLE (request withdrawn; halt_b returns to 1).
- SETTLE: halt_b=0, drive_AB=0. Counts down; at 0 -> GRANT. GUARD=0 means SETTLE is skipped and the FSM goes HALT_WAIT -> GRANT.
- GRANT: halt_b=0, drive_AB=1, dma_gnt=1.
  - dma_cycles increments each cycle; the grant counter counts cycles in the state.
  - dma_done=1 -> RELEASE.
  - Grant counter reaching MAX_DMA-1 without dma_done -> RELEASE, and overrun is set on the same edge.
  - dma_done and the timeout in the same cycle: normal release; overrun is not set.
- RELEASE: halt_b=0, drive_AB=0. Holds TURN cycles, then -> IDLE. TURN=0 means RELEASE lasts exactly 1 cycle.
- From IDLE after RELEASE, a still-high dma_req starts a new HALT_WAIT on the next edge. There is no back-to-back grant without re-halting.

Latency:
- dma_req rise to halt_b fall: 1 cycle.
- Qualifying cpu_cycle_end to drive_AB rise: GUARD+1 cycles.
- dma_done to drive_AB fall: 1 cycle.
- drive_AB fall to halt_b rise: TURN+1 cycles.

Invariants and boundary rules:
- drive_AB=1 implies halt_b=0 in every cycle; it never overlaps halt_b=1.
- dma_done outside GRANT is ignored.
- dma_req is not sampled in SETTLE/GRANT/RELEASE.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic burst, GUARD=2, TURN=1:
  - Stimulus: dma_req at t0; read cpu_cycle_end at t5; dma_done at t20.
  - Required: halt_b=0 from t1; drive_AB=1 t8..t20; halt_b=1 at t23; dma_cycles=13.
- Write-cycle deferral:
  - Stimulus: cpu_cycle_end with cpu_rd=0 at t3, then cpu_rd=1 at t9.
  - Required: remains in HALT_WAIT through t9; drive_AB rises at t12.
- Withdrawn request:
  - Stimulus: dma_req high t0..t4, no cpu_cycle_end.
  - Required: halt_b low t1..t5, back to 1 at t6; drive_AB never 1; dma_cycles=0.
- Timeout, MAX_DMA=8:
  - Stimulus: no dma_done.
  - Required: GRANT lasts exactly 8 cycles; overrun=1 and stays 1 after later normal bursts.
- Timeout/done collision:
  - Stimulus: dma_done on the 8th GRANT cycle with MAX_DMA=8.
  - Required: release; overrun stays 0.
- Asynchronous reset in GRANT:
  - Stimulus: assert reset between clock edges.
  - Required: drive_AB=0, halt_b=1, dma_cycles=0 immediately; dma_req held high restarts at HALT_WAIT after reset deasserts.
